nibble_serial_subtractor: RTL and testbench
===========================================

# nibble_serial_subtractor

Multi-cycle subtractor computing D = A − B − bin over WIDTH bits, one 4-bit nibble per clock. Each nibble uses a 4-bit borrow-lookahead slice, so it is the subtraction counterpart of the team's 4-bit carry-lookahead adder. The borrow is registered between nibbles. The block sits beside the adder in the ALU datapath and trades latency for area on wide operands. A start/busy/done handshake connects it to the controlling sequencer.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 4.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- bin  input  1  borrow-in; captured on the accepted start.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse when the result becomes valid.
- d  output  WIDTH  difference; held until the next completion.
- bout  output  1  borrow-out of the MSB nibble; high means A < B + bin as unsigned values.
- zero  output  1  high when d == 0.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- Reset state is IDLE. Reset values: busy=0, done=0, d=0, bout=0, zero=0, nibble index=0, internal borrow=0.
- **Start acceptance**
  - In IDLE or DONE, start=1 latches a, b and bin and moves the FSM to RUN with nibble index k=0.
  - In RUN, start is ignored and the captured operands are not disturbed.
- **Per-cycle slice in RUN** (nibble k, where x and y are the captured A and B nibbles and bi is the current borrow):
  - G = ~x & y and P = ~(x ^ y), per bit.
  - Borrow chain: b1 = G0|P0·bi, b2 = G1|P1·G0|P1·P0·bi, b3 and bo follow the same lookahead form.
  - Difference: dk = x ^ y ^ {b3,b2,b1,bi}.
  - dk is written into nibble k of an internal result register. bo becomes the borrow for the next cycle.
- After nibble N−1 (N = WIDTH/4) the FSM moves to DONE.
- On that transition:
  - d is loaded from the internal register in the same edge.
  - bout takes bo.
  - zero is computed from the final internal value.
- DONE lasts one cycle. The FSM then returns to IDLE, or goes directly to RUN if start=1 during DONE.
- Outputs d, bout and zero change only on the completion edge. They are stable across IDLE and across a following RUN.
- Arithmetic is modulo 2^WIDTH. The result is bit-identical to {bout,d} = {1'b0,a} − {1'b0,b} − bin, taken as unsigned with bout as the sign of the (WIDTH+1)-bit result.
- Reset asserted mid-operation aborts the operation immediately and asynchronously to the reset values. No done pulse is produced for the aborted operation.

## Timing
- start accepted at edge T.
- busy=1 for cycles T+1 … T+N. Nibble k is processed in cycle T+1+k.
- done=1 for exactly one cycle, T+N+1. d, bout and zero are valid from that cycle on.
- Latency from start to done is N+1 cycles. For WIDTH=16 that is 5 cycles.
- Back-to-back operation: start=1 during the done cycle is accepted, so throughput is one result per N+1 cycles.
- busy and done are never high together.

## Configuration
- Macro: SUB_OVERFLOW_EN.
- When defined:
  - An extra output port ovf (1 bit) is present, reset value 0.
  - It is updated on the completion edge with the signed overflow: (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]).
  - a and b here are the captured operands, and bin is included in d.
- When undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=16: a=0x1234, b=0x0034, bin=0 → done at T+5, d=0x1200, bout=0, zero=0.
- a=0x0000, b=0x0001, bin=0 → d=0xFFFF, bout=1. Also a=0x5555, b=0x5555, bin=0 → d=0x0000, bout=0, zero=1.
- a=0x8000, b=0x0000, bin=1 → d=0x7FFF, bout=0; ovf=1 with SUB_OVERFLOW_EN. Also a=0x7FFF, b=0xFFFF, bin=0 → d=0x8000, bout=1, ovf=1.
- start pulsed again at T+2 with different operands while busy → ignored; the result is still that of the first operands, with a single done pulse at T+5.
- rst asserted at T+3 during RUN → busy, d, bout and zero return to 0 immediately. No done pulse follows. A fresh start then completes normally.
- start held high during the done cycle with a new operand pair → busy rises the next cycle and the second done arrives 5 cycles after the first. The first d stays stable until the second done.

Source files
------------

// File: rtl/nibble_serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// nibble_serial_subtractor_if
//   Handshake and operand/result bundle between a controlling sequencer
//   (master) and the nibble-serial subtractor (slave).
//
//   start  master->slave  request, sampled by the slave only when not busy
//   a, b   master->slave  minuend / subtrahend, captured on accepted start
//   bin    master->slave  borrow-in, captured on accepted start
//   busy   slave->master  high while nibbles are being processed
//   done   slave->master  one-cycle completion pulse
//   d      slave->master  difference, held until the next completion
//   bout   slave->master  borrow-out of the MSB nibble
//   zero   slave->master  high when d == 0
//   ovf    slave->master  signed overflow (only with SUB_OVERFLOW_EN defined)
//
//   Optional feature macro: SUB_OVERFLOW_EN
// -----------------------------------------------------------------------------
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             zero;
`ifdef SUB_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, zero
`ifdef SUB_OVERFLOW_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, zero
`ifdef SUB_OVERFLOW_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// -----------------------------------------------------------------------------
// nibble_serial_subtractor
//   Computes D = A - B - bin over WIDTH bits, one 4-bit nibble per clock,
//   using a 4-bit borrow-lookahead slice per nibble with the borrow registered
//   between nibbles. Latency from accepted start to done is WIDTH/4 + 1 cycles.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   slave side of nibble_serial_subtractor_if
//           (start, a, b, bin in; busy, done, d, bout, zero[, ovf] out)
//
//   Parameter WIDTH: operand width, a multiple of 4 and >= 4.
//
//   Optional feature macro: SUB_OVERFLOW_EN
//     When defined, bus.ovf reports signed overflow of the completed result,
//     updated on the completion edge. When undefined the port and logic are
//     absent.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; result outputs hold the last completion
//   RUN   | processing nibble idx_q, borrow carried in borrow_q
//   DONE  | one-cycle completion pulse; start here begins a new operation
// -----------------------------------------------------------------------------
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  nibble_serial_subtractor_if.slave   bus
);

  localparam int N   = WIDTH / 4;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             zero_q;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_q;
`endif

  logic             capture;
  logic             step;
  logic             finish;
  logic             last_nibble;

  logic [3:0]       x_nib;
  logic [3:0]       y_nib;
  logic [3:0]       diff_nib;
  logic             bo_nib;
  logic [WIDTH-1:0] res_next;

  // 4-bit borrow-lookahead slice. g: this bit generates a borrow (0 - 1);
  // p: this bit propagates an incoming borrow (equal bits).
  // Returns {borrow_out, difference}.
  function automatic logic [4:0] sub_slice(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       bi);
    logic [3:0] g;
    logic [3:0] p;
    logic       b1, b2, b3, bo;
    g  = ~x & y;
    p  = ~(x ^ y);
    b1 = g[0] | (p[0] & bi);
    b2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    b3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
       | (p[2] & p[1] & p[0] & bi);
    bo = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bi);
    return {bo, x ^ y ^ {b3, b2, b1, bi}};
  endfunction

  // ---------------------------------------------------------------------------
  // Datapath: current nibble selection and slice evaluation
  // ---------------------------------------------------------------------------
  assign last_nibble = (idx_q == IW'(N - 1));

  always_comb begin
    x_nib    = a_q[{idx_q, 2'b00} +: 4];
    y_nib    = b_q[{idx_q, 2'b00} +: 4];
    {bo_nib, diff_nib} = sub_slice(x_nib, y_nib, borrow_q);
    // Full result with the current nibble merged in, so the completion edge
    // can publish d without waiting a cycle for res_q to settle.
    res_next = res_q;
    res_next[{idx_q, 2'b00} +: 4] = diff_nib;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_nibble) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          capture = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture, nibble stepping and result publication
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      res_q    <= '0;
    end else if (capture) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      borrow_q <= bus.bin;
      idx_q    <= '0;
    end else if (step) begin
      res_q    <= res_next;
      borrow_q <= bo_nib;
      idx_q    <= last_nibble ? '0 : idx_q + IW'(1);
    end
  end

  // Visible results change only on the completion edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q    <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (finish) begin
      d_q    <= res_next;
      bout_q <= bo_nib;
      zero_q <= (res_next == '0);
    end
  end

`ifdef SUB_OVERFLOW_EN
  // Signed overflow: operands of opposite sign and a result whose sign
  // differs from the minuend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (finish) begin
      ovf_q <= (a_q[MSB] != b_q[MSB]) && (res_next[MSB] != a_q[MSB]);
    end
  end
  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.d    = d_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_subtractor
//   Directed and random checks of nibble_serial_subtractor at WIDTH=16.
//   Expected results come from a (WIDTH+1)-bit reference subtraction pushed to
//   a scoreboard queue when an operation is issued and popped at done.
//   Honours SUB_OVERFLOW_EN for the ovf output.
// -----------------------------------------------------------------------------
module tb_nibble_serial_subtractor;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic             bin);
    exp_t           e;
    logic [WIDTH:0] r;
    r      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    e.d    = r[WIDTH-1:0];
    e.bout = r[WIDTH];
    e.zero = (r[WIDTH-1:0] == '0);
    e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Drive a request (call just after a clock edge) and record its expectation.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic bin);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    sb.push_back(model(a, b, bin));
  endtask

  // Clock the accepting edge and release start.
  task automatic accept();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done; reports edges waited, busy samples seen and
  // whether d moved before done.
  task automatic wait_done(output int lat, output int busy_cnt, output logic d_moved);
    logic [WIDTH-1:0] d0;
    d0       = bus.d;
    lat      = 0;
    busy_cnt = 0;
    d_moved  = 1'b0;
    while (!bus.done && lat < 20) begin
      chk("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.busy) busy_cnt++;
      if (bus.d !== d0) d_moved = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
    chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_d"},    {16'd0, bus.d},     {16'd0, e.d});
      chk({tag, "_bout"}, {31'd0, bus.bout},  {31'd0, e.bout});
      chk({tag, "_zero"}, {31'd0, bus.zero},  {31'd0, e.zero});
`ifdef SUB_OVERFLOW_EN
      chk({tag, "_ovf"},  {31'd0, bus.ovf},   {31'd0, e.ovf});
`endif
    end
  endtask

  // Full single operation with latency/busy/pulse-width checks.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic bin);
    int   lat;
    int   bc;
    logic moved;
    issue(a, b, bin);
    accept();
    wait_done(lat, bc, moved);
    chk({tag, "_latency"}, lat, N);
    chk({tag, "_busy_cycles"}, bc, N);
    chk({tag, "_d_stable"}, {31'd0, moved}, 32'd0);
    check_result(tag);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int               lat;
    int               bc;
    int               dones;
    logic             moved;
    logic [WIDTH-1:0] first_d;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_d",    {16'd0, bus.d},    32'd0);
    chk("rst_bout", {31'd0, bus.bout}, 32'd0);
    chk("rst_zero", {31'd0, bus.zero}, 32'd0);
`ifdef SUB_OVERFLOW_EN
    chk("rst_ovf",  {31'd0, bus.ovf},  32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed operand patterns
    run_op("op_1234", 16'h1234, 16'h0034, 1'b0);
    chk("op_1234_lit", {16'd0, bus.d}, 32'h1200);
    run_op("op_0m1",  16'h0000, 16'h0001, 1'b0);
    chk("op_0m1_lit", {15'd0, bus.bout, bus.d}, 32'h1FFFF);
    run_op("op_eq",   16'h5555, 16'h5555, 1'b0);
    chk("op_eq_zero_lit", {31'd0, bus.zero}, 32'd1);
    run_op("op_8000", 16'h8000, 16'h0000, 1'b1);
    chk("op_8000_lit", {16'd0, bus.d}, 32'h7FFF);
    run_op("op_7fff", 16'h7FFF, 16'hFFFF, 1'b0);
    chk("op_7fff_lit", {15'd0, bus.bout, bus.d}, 32'h18000);

    // start while busy is ignored
    issue(16'h1111, 16'h9ABC, 1'b0);
    accept();
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0001;
    bus.bin   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, bc, moved);
    chk("ign_latency", lat + 2, N);
    check_result("ign");
    dones = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk("ign_single_done", dones, 0);

    // Asynchronous reset mid-RUN
    issue(16'h4321, 16'h0021, 1'b1);
    accept();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_d",    {16'd0, bus.d},    32'd0);
    chk("abort_bout", {31'd0, bus.bout}, 32'd0);
    chk("abort_zero", {31'd0, bus.zero}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    dones = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk("abort_no_done", dones, 0);

    run_op("fresh", 16'hA5A5, 16'h5A5A, 1'b0);

    // Back-to-back: start held during the done cycle
    issue(16'h0F0F, 16'h00FF, 1'b1);
    accept();
    wait_done(lat, bc, moved);
    chk("b2b1_latency", lat, N);
    check_result("b2b1");
    first_d = bus.d;
    issue(16'h1000, 16'h2000, 1'b0);
    accept();
    chk("b2b2_busy_rise", {31'd0, bus.busy}, 32'd1);
    chk("b2b2_d_held", {16'd0, bus.d}, {16'd0, first_d});
    wait_done(lat, bc, moved);
    chk("b2b_gap", lat + 1, N + 1);
    chk("b2b_d_stable", {31'd0, moved}, 32'd0);
    check_result("b2b2");
    @(posedge clk);
    #1;

    // Random operands
    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      run_op("rand", ra, rb, 1'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
